instr_fetch: RTL and testbench

- Producer side of the decode interface: fetches 32-bit MIPS instruction words from instruction memory and presents op/funct plus the full word to the Controller/datapath.
- Owns the PC. Advances it by 4 on each accepted instruction, or redirects it to a target supplied by the execute stage on a taken branch or jump.
- Memory side uses a req/ack handshake with variable latency. Decode side uses valid/ready. One transaction outstanding; one-entry instruction register.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/pc_next_gen.sv | 50 +++++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: instruction field positions, NOP encoding,
// fetch FSM state encoding and the default reset PC.
package mips_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_gen.sv
// Combinational next-fetch-address selection for instr_fetch: chooses among
// RESET_PC, pc+4, the redirect target and the pending target; flags misalignment.
module pc_next_gen
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  fetch_state_t i_state,
  input  logic         i_imem_ack,
  input  logic         i_instr_ready,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_target,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_addr,
  input  logic [31:0]  i_pending_pc,
  output logic [31:0]  o_next_addr,
  output logic [31:0]  o_next_pending,
  output logic [31:0]  o_pc_plus4,
  output logic         o_align_err
);

  logic [31:0] w_target;

  assign w_target    = word_align(i_redirect_target);
  assign o_pc_plus4  = i_pc + 32'd4;
  assign o_align_err = i_redirect_valid && (i_redirect_target[1:0] != 2'b00);

  // Latching every redirect is harmless: pending_pc is only consumed in DROP.
  assign o_next_pending = i_redirect_valid ? w_target : i_pending_pc;

  always_comb begin
    o_next_addr = i_addr;
    case (i_state)
      ST_BOOT: o_next_addr = i_redirect_valid ? w_target : RESET_PC;
      ST_REQ: begin
        // Without ack the outstanding address must stay put.
        if (i_imem_ack && i_redirect_valid) o_next_addr = w_target;
      end
      ST_DROP: begin
        if (i_imem_ack) o_next_addr = i_redirect_valid ? w_target : i_pending_pc;
      end
      ST_HOLD: begin
        if (i_redirect_valid)   o_next_addr = w_target;
        else if (i_instr_ready) o_next_addr = o_pc_plus4;
      end
      default: o_next_addr = RESET_PC;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction fetch: owns the PC, fetches over a req/ack memory port and
// holds one instruction for decode (valid/ready); redirects drop in-flight work.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        align_err
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending;
  logic         r_align_err;
  logic         w_capture;
  logic [31:0]  w_next_addr;
  logic [31:0]  w_next_pending;
  logic         w_align_err;

  pc_next_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_next_gen (
    .i_state           (r_state),
    .i_imem_ack        (imem_ack),
    .i_instr_ready     (instr_ready),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_pc              (r_pc),
    .i_addr            (r_addr),
    .i_pending_pc      (r_pending),
    .o_next_addr       (w_next_addr),
    .o_next_pending    (w_next_pending),
    .o_pc_plus4        (pc_plus4),
    .o_align_err       (w_align_err)
  );

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_BOOT: w_next_state = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          // A same-cycle redirect makes the returned word stale.
          if (!redirect_valid) begin
            w_capture    = 1'b1;
            w_next_state = ST_HOLD;
          end
        end else if (redirect_valid) begin
          w_next_state = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) w_next_state = ST_REQ;
      end
      ST_HOLD: begin
        if (redirect_valid || instr_ready) w_next_state = ST_REQ;
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_BOOT;
      r_addr      <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc        <= RESET_PC;
      r_pending   <= RESET_PC;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_addr      <= w_next_addr;
      r_pending   <= w_next_pending;
      r_align_err <= w_align_err;
      if (w_capture) begin
        r_instr <= imem_rdata;
        r_pc    <= r_addr;
      end
    end
  end

  assign imem_req    = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign imem_addr   = r_addr;
  assign instr_valid = (r_state == ST_HOLD);
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign funct       = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign pc          = r_pc;
  assign align_err   = r_align_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed timing checks plus randomized
// memory latency, decode stalls and redirects against a program-flow model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        align_err;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .op              (op),
    .funct           (funct),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .align_err       (align_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the address of the next instruction decode should see.
  logic [31:0] m_next;
  logic        exp_align;
  logic        hold_vld;
  logic [31:0] hold_addr;
  int          n_acc;
  int          mem_mode;
  int          lat;
  int          lat_max;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return 32'h0000_0020;
    return (a ^ 32'h1234_5678) * 32'h9E37_79B1;
  endfunction

  task automatic model_reset();
    m_next    = 32'h0;
    exp_align = 1'b0;
    hold_vld  = 1'b0;
    hold_addr = 32'h0;
    lat       = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    w = mem_word(m_next);
    chk("align_err", 32'(align_err), 32'(exp_align));
    if (hold_vld) begin
      chk("req_held", 32'(imem_req), 1);
      chk("addr_held", imem_addr, hold_addr);
    end
    if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 0);
    if (instr_valid) begin
      chk("pc", pc, m_next);
      chk("instr", instr, w);
      chk("op", 32'(op), 32'(w[31:26]));
      chk("funct", 32'(funct), 32'(w[5:0]));
      chk("pc_plus4", pc_plus4, m_next + 32'd4);
    end
  endtask

  task automatic drive_mem();
    imem_ack = 1'b0;
    if (imem_req) begin
      if (lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        lat        = $urandom_range(0, lat_max);
      end else begin
        imem_rdata = $urandom;
        lat--;
      end
    end
  endtask

  task automatic model_update();
    hold_vld  = imem_req && !imem_ack;
    hold_addr = imem_addr;
    exp_align = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (redirect_valid) begin
      m_next = {redirect_target[31:2], 2'b00};
    end else if (instr_valid && instr_ready) begin
      m_next = m_next + 32'd4;
      n_acc++;
    end
  endtask

  task automatic run_cycle(input logic rv, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    check_outputs();
    drive_mem();
    redirect_valid  = rv;
    redirect_target = tgt;
    instr_ready     = rdy;
    model_update();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_op"}, 32'(op), 0);
    chk({tag, "_funct"}, 32'(funct), 0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pc_plus4, 32'h4);
    chk({tag, "_align"}, 32'(align_err), 0);
  endtask

  task automatic do_reset(input int mode);
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    mem_mode = mode;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] tgt;
    logic        rv;
    n_acc    = 0;
    mem_mode = 0;
    lat_max  = 0;
    model_reset();

    // Test 1: ack and ready tied high, add instruction.
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    #1;
    chk("boot_req", 32'(imem_req), 0);
    run_cycle(0, 0, 1);
    chk("t1_req_c2", 32'(imem_req), 1);
    chk("t1_addr_c2", imem_addr, 32'h0);
    chk("t1_valid_c2", 32'(instr_valid), 0);
    run_cycle(0, 0, 1);
    chk("t1_valid_c3", 32'(instr_valid), 1);
    chk("t1_funct_c3", 32'(funct), 32'h20);
    chk("t1_pc_c3", pc, 32'h0);
    run_cycle(0, 0, 1);
    chk("t1_addr4", imem_addr, 32'h4);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 1);
    chk("t1_addr8", imem_addr, 32'h8);

    // Test 3: decode stall keeps the instruction and blocks new requests.
    for (int i = 0; i < 10 && !instr_valid; i++) run_cycle(0, 0, 0);
    chk("t3_valid", 32'(instr_valid), 1);
    held_pc = m_next;
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 0);
      chk("t3_no_req", 32'(imem_req), 0);
    end
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 0);
    chk("t3_next_addr", imem_addr, held_pc + 32'd4);

    // Randomized phase: variable latency, stalls, aligned and misaligned redirects.
    do_reset(1);
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'hFFFF_F000;
      run_cycle(rv, tgt, ($urandom_range(0, 9) < 7));
    end

    // Test 6: wrap past the top of the address space, then async reset mid-REQ.
    run_cycle(1, 32'hFFFF_FFFC, 0);
    run_cycle(0, 0, 0);
    for (int i = 0; i < 20 && !instr_valid; i++) run_cycle(0, 0, 0);
    chk("t6_valid", 32'(instr_valid), 1);
    chk("t6_pc", pc, 32'hFFFF_FFFC);
    run_cycle(0, 0, 1);
    lat = 3;
    run_cycle(0, 0, 0);
    chk("t6_wrap_req", 32'(imem_req), 1);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    imem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      tgt = 32'($urandom_range(0, 4095));
      run_cycle(rv, tgt, ($urandom_range(0, 3) != 0));
    end
    chk("progress", 32'(n_acc > 300), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
